uart_rx_sample_timer: RTL and testbench
=======================================

# uart_rx_sample_timer

Parametrised oversampling timer for the UART receive path. It sits between the start-bit detector and the data sampler/deserialiser. Once enabled, it counts oversampling edges per bit and bits per frame, and generates mid-bit sample strobes, bit-boundary strobes and an end-of-frame strobe. It extends the fixed-width edge/bit counter with a per-frame configuration latch, run/done sequencing, mid-frame realignment and an optional three-point sample window.

## Interface
Parameters:
- PRESCALE_W, 6: width of prescale and edge_cnt; supports ratios up to 2^PRESCALE_W-1.
- BIT_CNT_W, 4: width of frame_bits and bit_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run request from the start detector; low aborts and clears the frame.
- prescale  in  PRESCALE_W  oversampling clocks per bit; effective P = max(prescale, 4).
- frame_bits  in  BIT_CNT_W  bits per frame, including start/parity/stop; effective F = max(frame_bits, 1).
- realign  in  1  resynchronise: the current cycle becomes edge 0 of the current bit.
- edge_cnt  out  PRESCALE_W  current edge index within the bit.
- bit_cnt  out  BIT_CNT_W  current bit index within the frame.
- sample_stb  out  1  mid-bit sample pulse.
- bit_done  out  1  last-edge-of-bit pulse.
- frame_done  out  1  last-edge-of-frame pulse.
- busy  out  1  high while in RUN.
- sample_pre, sample_post  out  1  each; present only with UART_RX_TRIPLE_SAMPLE_EN.

## Operation
- The FSM states are IDLE, RUN and DONE. The state, edge_cnt, bit_cnt and the config latch are registered.
- en low, in any state, has highest priority: next state is IDLE, edge_cnt <= 0, bit_cnt <= 0.
- IDLE with en=1:
  - Latch P and F from the effective prescale and frame_bits values.
  - The current cycle counts as edge 0: edge_cnt <= 1, bit_cnt <= 0, next state is RUN.
- RUN, in priority order after en:
  1. realign: edge_cnt <= 1 (the current cycle is edge 0); bit_cnt is unchanged; no strobes fire this cycle.
  2. edge_cnt == P-1 and bit_cnt == F-1: frame_done and bit_done fire; edge_cnt <= 0, bit_cnt <= F, next state is DONE.
  3. edge_cnt == P-1: bit_done fires; edge_cnt <= 0, bit_cnt <= bit_cnt+1.
  4. Otherwise: edge_cnt <= edge_cnt+1.
- DONE: counters hold; no strobes; remains in DONE until en goes low. A new frame therefore requires en to drop for at least one cycle.
- Mid point M = P>>1, computed from the latched P.
- sample_stb = (state==RUN) && edge_cnt==M && !realign.
- With the macro enabled, sample_pre and sample_post decode edge_cnt == M-1 and M+1 under the same qualification.
- Changes to prescale or frame_bits during RUN or DONE are ignored until the next IDLE exit.
- All compares use the latched, zero-extended values. Counters never exceed P-1 and F.

## Timing
- Reset values: state IDLE, edge_cnt 0, bit_cnt 0, latched P=4 and F=1; all strobes 0; busy 0.
- The strobes and busy are combinational decodes of registered state with zero added latency. Each strobe is high for exactly one clk cycle per event.
- For the first bit, sample_stb fires M cycles after the en-high IDLE cycle (which counts as cycle 0). bit_done fires at cycle P-1. Frame_done fires at cycle F*P-1.
- busy rises in the cycle after the en-high IDLE cycle. It falls in the cycle after frame_done, or in the cycle after en goes low.
- en low in the same cycle as a wrap or frame_done: the abort wins for next state, but the strobes decoded in that cycle still fire. Downstream logic gates them with en.
- realign in the same cycle as a wrap: the realign wins and bit_cnt does not advance.
- Asynchronous reset mid-frame returns to the reset values immediately. No strobes fire while reset is asserted.

## Configuration
- UART_RX_TRIPLE_SAMPLE_EN defined: adds the sample_pre and sample_post ports and decoders, which feed 3-sample majority voting in the sampler. The minimum P of 4 guarantees that M-1 >= 1 and M+1 <= P-1.
- Undefined: those ports and decoders are absent; only sample_stb is generated. All other behaviour is identical.

## Structure
- Package uart_rx_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - MIN_PRESCALE = 4 and MIN_FRAME_BITS = 1;
  - the PRESCALE_W and BIT_CNT_W defaults.
- Sub-module uart_rx_strobe_decode holds the purely combinational decoding: it takes state, edge_cnt, bit_cnt, P, F and realign, and produces all strobes and busy. The counters and FSM remain in the top module.

## Test plan
- P=8, F=10, en held high: sample_stb at cycles 4, 12, …, 76; bit_done 10 times at cycles 7+8k; frame_done at cycle 79; bit_cnt=10 in DONE; busy low from cycle 80.
- prescale=2, F=1: effective P=4; sample_stb at cycle 2, bit_done and frame_done at cycle 3.
- P=16, F=10, en dropped at cycle 37: next cycle state IDLE, counters 0, busy 0; no frame_done.
- P=16, realign pulsed at edge_cnt=5 of bit 2: next edge_cnt=1, bit_cnt stays 2; sample_stb 8 cycles after the realign.
- prescale changed from 8 to 16 during RUN: frame timing stays at P=8. The next frame, after en low then high, uses 16.
- Macro enabled, P=16: sample_pre, sample_stb and sample_post fire at edges 7, 8 and 9 of every bit. rst asserted mid-bit: all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive timer.
// Holds the timer FSM state enum, the prescale/frame floors and default widths.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_FRAME_BITS = 1;

  localparam int PRESCALE_W_DEF = 6;
  localparam int BIT_CNT_W_DEF  = 4;

endpackage

// File: rtl/uart_rx_strobe_decode.sv
// uart_rx_strobe_decode: combinational strobe/busy decode for the RX timer.
// In: state, edge_cnt, bit_cnt, latched p/f, realign.
// Out: sample_stb, bit_done, frame_done, busy
//      (+ sample_pre/sample_post with UART_RX_TRIPLE_SAMPLE_EN).
module uart_rx_strobe_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  state_t                state,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [BIT_CNT_W-1:0]  bit_cnt,
  input  logic [PRESCALE_W-1:0] p,
  input  logic [BIT_CNT_W-1:0]  f,
  input  logic                  realign,
  output logic                  sample_stb,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy
`ifdef UART_RX_TRIPLE_SAMPLE_EN
  ,
  output logic                  sample_pre,
  output logic                  sample_post
`endif
);

  logic                  act;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] p_last;
  logic [BIT_CNT_W-1:0]  f_last;

  // realign suppresses every strobe in the cycle it is seen
  assign act    = (state == RUN) && !realign;
  assign mid    = p >> 1;
  assign p_last = p - 1'b1;
  assign f_last = f - 1'b1;

  assign busy       = (state == RUN);
  assign sample_stb = act && (edge_cnt == mid);
  assign bit_done   = act && (edge_cnt == p_last);
  assign frame_done = bit_done && (bit_cnt == f_last);

`ifdef UART_RX_TRIPLE_SAMPLE_EN
  // p >= 4 keeps mid-1 and mid+1 inside [1, p-1]
  assign sample_pre  = act && (edge_cnt == mid - 1'b1);
  assign sample_post = act && (edge_cnt == mid + 1'b1);
`endif

endmodule

// File: rtl/uart_rx_sample_timer.sv
// uart_rx_sample_timer: oversampling edge/bit timer for the UART RX path.
// In: clk, rst (async, low), en, prescale, frame_bits, realign.
// Out: edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy;
//      sample_pre/sample_post when UART_RX_TRIPLE_SAMPLE_EN is defined.
module uart_rx_sample_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  input  logic                  realign,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy
`ifdef UART_RX_TRIPLE_SAMPLE_EN
  ,
  output logic                  sample_pre,
  output logic                  sample_post
`endif
);

  localparam logic [PRESCALE_W-1:0] P_MIN =
    PRESCALE_W'(MIN_PRESCALE);
  localparam logic [BIT_CNT_W-1:0]  F_MIN =
    BIT_CNT_W'(MIN_FRAME_BITS);
  localparam logic [PRESCALE_W-1:0] EDGE_ONE =
    PRESCALE_W'(1);

  state_t                state_q, state_n;
  logic [PRESCALE_W-1:0] edge_q, edge_n;
  logic [BIT_CNT_W-1:0]  bit_q, bit_n;
  logic [PRESCALE_W-1:0] p_q, p_n;
  logic [BIT_CNT_W-1:0]  f_q, f_n;

  logic [PRESCALE_W-1:0] p_eff;
  logic [BIT_CNT_W-1:0]  f_eff;

  assign p_eff = (prescale < P_MIN) ? P_MIN : prescale;
  assign f_eff = (frame_bits < F_MIN) ? F_MIN : frame_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= P_MIN;
      f_q     <= F_MIN;
    end else begin
      state_q <= state_n;
      edge_q  <= edge_n;
      bit_q   <= bit_n;
      p_q     <= p_n;
      f_q     <= f_n;
    end
  end

  // bit_done/frame_done already exclude realign, so the RUN
  // priority chain below can lean on them directly
  always_comb begin
    state_n = state_q;
    edge_n  = edge_q;
    bit_n   = bit_q;
    p_n     = p_q;
    f_n     = f_q;
    if (!en) begin
      state_n = IDLE;
      edge_n  = '0;
      bit_n   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          p_n     = p_eff;
          f_n     = f_eff;
          edge_n  = EDGE_ONE;
          bit_n   = '0;
          state_n = RUN;
        end
        RUN: begin
          if (realign) begin
            edge_n = EDGE_ONE;
          end else if (frame_done) begin
            edge_n  = '0;
            bit_n   = f_q;
            state_n = DONE;
          end else if (bit_done) begin
            edge_n = '0;
            bit_n  = bit_q + 1'b1;
          end else begin
            edge_n = edge_q + 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          state_n = IDLE;
          edge_n  = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

  uart_rx_strobe_decode #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_dec (
    .state       (state_q),
    .edge_cnt    (edge_q),
    .bit_cnt     (bit_q),
    .p           (p_q),
    .f           (f_q),
    .realign     (realign),
    .sample_stb  (sample_stb),
    .bit_done    (bit_done),
    .frame_done  (frame_done),
    .busy        (busy)
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    ,
    .sample_pre  (sample_pre),
    .sample_post (sample_post)
`endif
  );

endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// tb_uart_rx_sample_timer: directed and randomized bench for the RX timer.
// Cycle-indexed expectations plus an anchor/modulo reference model.
module tb_uart_rx_sample_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          realign;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_bits;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_stb;
  logic          bit_done;
  logic          frame_done;
  logic          busy;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
  logic          sample_pre;
  logic          sample_post;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_rx_sample_timer #(
    .PRESCALE_W (PW),
    .BIT_CNT_W  (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .frame_bits  (frame_bits),
    .realign     (realign),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sample_stb  (sample_stb),
    .bit_done    (bit_done),
    .frame_done  (frame_done),
    .busy        (busy)
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    ,
    .sample_pre  (sample_pre),
    .sample_post (sample_post)
`endif
  );

  function automatic logic [13:0] obs();
    return {edge_cnt, bit_cnt, busy,
            sample_stb, bit_done, frame_done};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_en();
    next_cycle();
    en = 1'b0;
    realign = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (obs() !== 14'd0)
      $display("FAIL reset_hold got %h exp 0", obs());
    else passed++;
    next_cycle();
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== 14'd0)
      $display("FAIL reset_release got %h exp 0", obs());
    else passed++;
    next_cycle();
    #1;
    total++;
    if (obs() !== 14'd0)
      $display("FAIL idle_en_low got %h exp 0", obs());
    else passed++;
  endtask

  task automatic test_p8_f10();
    next_cycle();
    en = 1'b1;
    prescale = 6'd8;
    frame_bits = 4'd10;
    #1;
    total++;
    if ({busy, sample_stb, bit_done, frame_done} !== 4'b0)
      $display("FAIL p8_c0 got %b exp 0000",
               {busy, sample_stb, bit_done, frame_done});
    else passed++;
    for (int c = 1; c <= 85; c++) begin
      logic [3:0] e;
      next_cycle();
      #1;
      e = {c < 80, c < 80 && c % 8 == 4,
           c < 80 && c % 8 == 7, c == 79};
      total++;
      if ({busy, sample_stb, bit_done, frame_done} !== e)
        $display("FAIL p8_strobes c=%0d got %b exp %b", c,
                 {busy, sample_stb, bit_done, frame_done}, e);
      else passed++;
    end
    total++;
    if ({edge_cnt, bit_cnt} !== {6'd0, 4'd10})
      $display("FAIL p8_done_cnt got %0d/%0d exp 0/10",
               edge_cnt, bit_cnt);
    else passed++;
    drop_en();
  endtask

  task automatic test_min_prescale();
    next_cycle();
    en = 1'b1;
    prescale = 6'd2;
    frame_bits = 4'd1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      logic [3:0] e;
      next_cycle();
      #1;
      e = {c <= 3, c == 2, c == 3, c == 3};
      total++;
      if ({busy, sample_stb, bit_done, frame_done} !== e)
        $display("FAIL minp_strobes c=%0d got %b exp %b", c,
                 {busy, sample_stb, bit_done, frame_done}, e);
      else passed++;
    end
    total++;
    if (bit_cnt !== 4'd1)
      $display("FAIL minp_bitcnt got %0d exp 1", bit_cnt);
    else passed++;
    drop_en();
  endtask

  task automatic test_abort();
    next_cycle();
    en = 1'b1;
    prescale = 6'd16;
    frame_bits = 4'd10;
    #1;
    for (int c = 1; c <= 38; c++) begin
      logic [13:0] e;
      next_cycle();
      if (c == 37) en = 1'b0;
      #1;
      if (c <= 37)
        e = {6'(c % 16), 4'(c / 16), 1'b1,
             c % 16 == 8, c % 16 == 15, 1'b0};
      else
        e = 14'd0;
      total++;
      if (obs() !== e)
        $display("FAIL abort c=%0d got %h exp %h", c, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_realign();
    next_cycle();
    en = 1'b1;
    prescale = 6'd16;
    frame_bits = 4'd10;
    #1;
    for (int c = 1; c <= 60; c++) begin
      logic [13:0] e;
      int ed, bt;
      next_cycle();
      realign = (c == 37 || c == 52);
      #1;
      if (c <= 37) begin
        ed = c % 16;
        bt = c / 16;
      end else if (c <= 52) begin
        ed = c - 37;
        bt = 2;
      end else begin
        ed = c - 52;
        bt = 2;
      end
      e = {6'(ed), 4'(bt), 1'b1,
           !realign && ed == 8,
           !realign && ed == 15, 1'b0};
      total++;
      if (obs() !== e)
        $display("FAIL realign c=%0d got %h exp %h",
                 c, obs(), e);
      else passed++;
    end
    drop_en();
  endtask

  task automatic test_config_latch();
    prescale = 6'd8;
    frame_bits = 4'd2;
    for (int fr = 0; fr < 2; fr++) begin
      int pl, len;
      pl  = (fr == 0) ? 8 : 16;
      len = (fr == 0) ? 16 : 80;
      next_cycle();
      en = 1'b1;
      #1;
      for (int c = 1; c <= len + 2; c++) begin
        logic [3:0] e;
        next_cycle();
        if (fr == 0 && c == 3) begin
          prescale = 6'd16;
          frame_bits = 4'd5;
        end
        #1;
        e = {c < len, c < len && c % pl == pl / 2,
             c < len && c % pl == pl - 1, c == len - 1};
        total++;
        if ({busy, sample_stb, bit_done, frame_done} !== e)
          $display("FAIL latch f%0d c=%0d got %b exp %b",
                   fr, c,
                   {busy, sample_stb, bit_done, frame_done}, e);
        else passed++;
      end
      drop_en();
    end
  endtask

`ifdef UART_RX_TRIPLE_SAMPLE_EN
  task automatic test_triple();
    next_cycle();
    en = 1'b1;
    prescale = 6'd16;
    frame_bits = 4'd2;
    #1;
    for (int c = 1; c <= 33; c++) begin
      logic [2:0] e;
      next_cycle();
      #1;
      e = {c < 32 && c % 16 == 7, c < 32 && c % 16 == 8,
           c < 32 && c % 16 == 9};
      total++;
      if ({sample_pre, sample_stb, sample_post} !== e)
        $display("FAIL triple c=%0d got %b exp %b", c,
                 {sample_pre, sample_stb, sample_post}, e);
      else passed++;
    end
    drop_en();
  endtask
`endif

  task automatic test_async_reset();
    logic [15:0] o;
    next_cycle();
    en = 1'b1;
    prescale = 6'd16;
    frame_bits = 4'd2;
    #1;
    for (int c = 1; c <= 24; c++) next_cycle();
    #1;
    total++;
    if (sample_stb !== 1'b1)
      $display("FAIL arst_pre got %b exp 1", sample_stb);
    else passed++;
    rst = 1'b0;
    #1;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    o = {obs(), sample_pre, sample_post};
`else
    o = {obs(), 2'b00};
`endif
    total++;
    if (o !== 16'd0)
      $display("FAIL arst_mid got %h exp 0", o);
    else passed++;
    en = 1'b0;
    #2;
    rst = 1'b1;
    next_cycle();
    #1;
    total++;
    if (obs() !== 14'd0)
      $display("FAIL arst_after got %h exp 0", obs());
    else passed++;
  endtask

  // Reference: a frame is an anchor cycle 'a' that counts as edge 0
  // of bit 'b0'; position follows by division/modulo of elapsed time.
  task automatic test_random();
    int act, a, b0, pm, fm, k, bt, ed, n, len;
    bit bsy;
    logic [13:0] e;
    act = 0;
    a = 0;
    b0 = 0;
    pm = 4;
    fm = 1;
    n = 0;
    for (int fr = 0; fr < 15; fr++) begin
      prescale = 6'($urandom_range(0, 20));
      frame_bits = 4'($urandom_range(0, 15));
      len = 5 + ((prescale < 4) ? 4 : int'(prescale)) *
            ((frame_bits == 0) ? 1 : int'(frame_bits));
      for (int c = 0; c < len; c++) begin
        next_cycle();
        en = (c == 0) ? 1'b1 :
             ($urandom_range(0, 149) != 0);
        realign = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 19) == 0) begin
          prescale = 6'($urandom_range(0, 20));
          frame_bits = 4'($urandom_range(0, 15));
        end
        #1;
        bsy = 1'b0;
        ed = 0;
        bt = 0;
        if (act != 0) begin
          k = n - a;
          bt = b0 + k / pm;
          if (bt >= fm) bt = fm;
          else begin
            ed = k % pm;
            bsy = 1'b1;
          end
        end
        e = {6'(ed), 4'(bt), bsy,
             bsy && !realign && ed == pm / 2,
             bsy && !realign && ed == pm - 1,
             bsy && !realign && ed == pm - 1 && bt == fm - 1};
        total++;
        if (obs() !== e)
          $display("FAIL random n=%0d got %h exp %h",
                   n, obs(), e);
        else passed++;
        if (!en) act = 0;
        else if (act == 0) begin
          act = 1;
          a = n;
          b0 = 0;
          pm = (prescale < 4) ? 4 : int'(prescale);
          fm = (frame_bits == 0) ? 1 : int'(frame_bits);
        end else if (bsy && realign) begin
          a = n;
          b0 = bt;
        end
        n++;
      end
      drop_en();
      act = 0;
      n++;
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    realign = 1'b0;
    prescale = 6'd8;
    frame_bits = 4'd10;
    test_reset();
    test_p8_f10();
    test_min_prescale();
    test_abort();
    test_realign();
    test_config_latch();
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    test_triple();
`endif
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
